// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue
//   Decoupled fetch stage. Owns the fetch PC and issues one sync-read request
//   per cycle to imem/icache. Each returned word is buffered with its PC in a
//   DEPTH-entry FIFO and handed to decode over a valid/ready handshake.
//   A redirect flushes the FIFO and kills the response of the request issued
//   in the previous cycle.
//
//   Build option: define FETCH_BYPASS_EN to forward a live response straight
//   to decode when the FIFO is empty. Left undefined, out_valid comes from
//   registered state only.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   stall          global memory stall, freezes every register
//   redirect       take redirect_pc this cycle
//   redirect_pc    redirect target (bits [1:0] ignored)
//   icache_addr    fetch address (combinational)
//   icache_re      fetch request (combinational)
//   instruction    imem data, valid one cycle after an accepted request
//   out_valid      instruction valid towards decode
//   out_ready      decode accepts
//   out_inst       instruction (NOP_INST when out_valid is low)
//   out_pc         PC of out_inst
//   out_pc_plus4   out_pc + 4, wrapping at 2^PC_WIDTH
//   level          FIFO occupancy
module riscv_fetch_queue #(
  parameter int                  PC_WIDTH = 14,
  parameter int                  DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]         NOP_INST = 32'h0000_0013,
  localparam int                 AW       = $clog2(DEPTH),
  localparam int                 LW       = AW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] icache_addr,
  output logic                icache_re,
  input  logic [31:0]         instruction,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [PC_WIDTH-1:0] out_pc_plus4,
  output logic [LW-1:0]       level
);

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                inflight;
  logic [31:0]         q_inst [DEPTH];
  logic [PC_WIDTH-1:0] q_pc   [DEPTH];
  logic [AW-1:0]       head;
  logic [AW-1:0]       tail;
  logic [LW-1:0]       level_q;

  logic                active;
  logic [PC_WIDTH-1:0] target_pc;
  logic [LW-1:0]       credit_level;
  logic [LW:0]         credit_sum;
  logic                resp_live;
  logic                fifo_empty;
  logic                bypass_hit;
  logic                handshake;
  logic                enq;
  logic                deq;
  logic                unused_pc_lsbs;

  assign active         = !rst && !stall;
  assign target_pc      = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Credit counts the FIFO as empty in a redirect cycle because the flush
  // lands on the same edge. The in-flight request is still counted even
  // though it is about to be killed; this keeps the rule conservative.
  assign credit_level = redirect ? '0 : level_q;
  assign credit_sum   = {1'b0, credit_level} + {{LW{1'b0}}, inflight};

  assign icache_re   = active && (credit_sum < (LW+1)'(DEPTH));
  assign icache_addr = redirect ? target_pc : fetch_pc;

  // A response is live on the cycle after issue unless a redirect kills it.
  assign resp_live  = active && inflight && !redirect;
  assign fifo_empty = (level_q == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = resp_live && fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign out_valid    = !fifo_empty || bypass_hit;
  assign out_inst     = bypass_hit  ? instruction :
                        !fifo_empty ? q_inst[head] : NOP_INST;
  assign out_pc       = bypass_hit ? inflight_pc : q_pc[head];
  assign out_pc_plus4 = out_pc + PC_WIDTH'(4);
  assign level        = level_q;

  // Handshakes are ignored while stalled and in a redirect cycle.
  assign handshake = active && !redirect && out_valid && out_ready;

  // A bypassed word that decode takes never touches the FIFO.
  assign deq = handshake && !bypass_hit;
  assign enq = resp_live && !(bypass_hit && handshake);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      level_q     <= '0;
    end else if (!stall) begin
      inflight <= icache_re;
      if (icache_re) begin
        inflight_pc <= icache_addr;
        fetch_pc    <= icache_addr + PC_WIDTH'(4);
      end else if (redirect) begin
        fetch_pc <= target_pc;
      end

      if (redirect) begin
        head    <= tail;
        level_q <= '0;
      end else begin
        if (enq) tail <= tail + AW'(1);
        if (deq) head <= head + AW'(1);
        level_q <= level_q + LW'(enq) - LW'(deq);
      end
    end
  end

  // Storage needs no reset: nothing is read until level_q says it was written.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_inst[tail] <= instruction;
      q_pc[tail]   <= inflight_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(enq && !redirect && level_q == LW'(DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(deq && fifo_empty));

endmodule

// File: tb/tb_riscv_fetch_queue.sv
module tb_riscv_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int          LAT        = 1;
  localparam logic [13:0] STALL_PC   = 14'd20;
  localparam logic [2:0]  STALL_LVL  = 3'd0;
  localparam logic        STALL_V    = 1'b0;
`else
  localparam int          LAT        = 2;
  localparam logic [13:0] STALL_PC   = 14'd16;
  localparam logic [2:0]  STALL_LVL  = 3'd1;
  localparam logic        STALL_V    = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [13:0] redirect_pc;
  logic [13:0] icache_addr;
  logic        icache_re;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [13:0] out_pc;
  logic [13:0] out_pc_plus4;
  logic [2:0]  level;

  int n_vec = 0;
  int n_err = 0;

  riscv_fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .icache_addr  (icache_addr),
    .icache_re    (icache_re),
    .instruction  (instruction),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .level        (level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return 32'hC0DE_0000 | {18'd0, a};
  endfunction

  // Sync-read memory: data for an accepted request appears next cycle and
  // holds while no new request is accepted.
  always @(posedge clk) begin
    if (icache_re) instruction <= mem_word(icache_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic ready);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = ready;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    #1;
    n_vec++; if (icache_re !== 1'b0) begin n_err++; $display("FAIL reset_re_in_reset: got %b expected 0", icache_re); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_inst !== NOP) begin n_err++; $display("FAIL reset_nop: got %h expected %h", out_inst, NOP); end
    n_vec++; if (icache_addr !== 14'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0000", icache_addr); end
    n_vec++; if (icache_re !== 1'b1) begin n_err++; $display("FAIL reset_re: got %b expected 1", icache_re); end
  endtask

  task automatic test_stream();
    logic [13:0] exp_pc;
    do_reset(1'b1);
    exp_pc = '0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_vec++; if (icache_addr !== 14'(4*k)) begin n_err++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, icache_addr, 14'(4*k)); end
      if (k >= LAT) begin
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, out_valid); end
        n_vec++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, out_pc, exp_pc); end
        n_vec++; if (out_inst !== mem_word(exp_pc)) begin n_err++; $display("FAIL stream_inst[%0d]: got %h expected %h", k, out_inst, mem_word(exp_pc)); end
        n_vec++; if (out_pc_plus4 !== exp_pc + 14'd4) begin n_err++; $display("FAIL stream_pc4[%0d]: got %h expected %h", k, out_pc_plus4, exp_pc + 14'd4); end
        exp_pc = exp_pc + 14'd4;
      end else begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_early_valid[%0d]: got %b expected 0", k, out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] lvl_tab [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    logic       re_tab  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_vec++; if (level !== lvl_tab[k]) begin n_err++; $display("FAIL bp_level[%0d]: got %0d expected %0d", k, level, lvl_tab[k]); end
      n_vec++; if (icache_re !== re_tab[k]) begin n_err++; $display("FAIL bp_re[%0d]: got %b expected %b", k, icache_re, re_tab[k]); end
    end
    n_vec++; if (out_pc !== 14'h0) begin n_err++; $display("FAIL bp_head_pc: got %h expected 0000", out_pc); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b expected 1", k, out_valid); end
      n_vec++; if (out_pc !== 14'(4*k)) begin n_err++; $display("FAIL drain_pc[%0d]: got %h expected %h", k, out_pc, 14'(4*k)); end
      n_vec++; if (out_inst !== mem_word(14'(4*k))) begin n_err++; $display("FAIL drain_inst[%0d]: got %h expected %h", k, out_inst, mem_word(14'(4*k))); end
    end
  endtask

  task automatic test_redirect_flush();
    logic [13:0] exp_pc;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    #1;
    n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL flush_pre_level: got %0d expected 3", level); end
    redirect = 1'b1; redirect_pc = 14'h104;
    #1;
    n_vec++; if (icache_addr !== 14'h104) begin n_err++; $display("FAIL flush_addr: got %h expected 0104", icache_addr); end
    n_vec++; if (icache_re !== 1'b1) begin n_err++; $display("FAIL flush_re: got %b expected 1", icache_re); end
    @(negedge clk);
    redirect = 1'b0; out_ready = 1'b1;
    #1;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL flush_level: got %0d expected 0", level); end
    exp_pc = 14'h104;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      if (k >= LAT) begin
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_valid[%0d]: got %b expected 1", k, out_valid); end
        n_vec++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL flush_pc[%0d]: got %h expected %h", k, out_pc, exp_pc); end
        exp_pc = exp_pc + 14'd4;
      end else begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_early_valid[%0d]: got %b expected 0", k, out_valid); end
      end
    end
  endtask

  task automatic test_align_wrap();
    logic [13:0] exp_pc;
    do_reset(1'b1);
    redirect = 1'b1; redirect_pc = 14'h203;
    #1;
    n_vec++; if (icache_addr !== 14'h200) begin n_err++; $display("FAIL align_addr: got %h expected 0200", icache_addr); end
    n_vec++; if (icache_re !== 1'b1) begin n_err++; $display("FAIL align_re: got %b expected 1", icache_re); end
    @(negedge clk);
    redirect_pc = 14'h3FFF;
    #1;
    n_vec++; if (icache_addr !== 14'h3FFC) begin n_err++; $display("FAIL wrap_target: got %h expected 3ffc", icache_addr); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_vec++; if (icache_addr !== 14'h0000) begin n_err++; $display("FAIL wrap_addr: got %h expected 0000", icache_addr); end
    n_vec++; if (icache_re !== 1'b1) begin n_err++; $display("FAIL wrap_re: got %b expected 1", icache_re); end
    exp_pc = 14'h3FFC;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      if (k >= LAT - 1) begin
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid[%0d]: got %b expected 1", k, out_valid); end
        n_vec++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL wrap_pc[%0d]: got %h expected %h", k, out_pc, exp_pc); end
        n_vec++; if (out_pc_plus4 !== exp_pc + 14'd4) begin n_err++; $display("FAIL wrap_pc4[%0d]: got %h expected %h", k, out_pc_plus4, exp_pc + 14'd4); end
        exp_pc = exp_pc + 14'd4;
      end
    end
  endtask

  task automatic test_stall();
    logic [13:0] exp_pc;
    do_reset(1'b1);
    exp_pc = '0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (out_valid) begin
        n_vec++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL stall_pre_pc[%0d]: got %h expected %h", k, out_pc, exp_pc); end
        exp_pc = exp_pc + 14'd4;
      end
    end
    n_vec++; if (exp_pc !== STALL_PC) begin n_err++; $display("FAIL stall_pre_count: next pc %h expected %h", exp_pc, STALL_PC); end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      stall = 1'b1;
      redirect = (s >= 1 && s <= 3);
      redirect_pc = 14'h300;
      #1;
      n_vec++; if (icache_re !== 1'b0) begin n_err++; $display("FAIL stall_re[%0d]: got %b expected 0", s, icache_re); end
      n_vec++; if (level !== STALL_LVL) begin n_err++; $display("FAIL stall_level[%0d]: got %0d expected %0d", s, level, STALL_LVL); end
      n_vec++; if (out_valid !== STALL_V) begin n_err++; $display("FAIL stall_valid[%0d]: got %b expected %b", s, out_valid, STALL_V); end
`ifdef FETCH_BYPASS_EN
      n_vec++; if (out_inst !== NOP) begin n_err++; $display("FAIL stall_inst[%0d]: got %h expected %h", s, out_inst, NOP); end
`else
      n_vec++; if (out_pc !== STALL_PC) begin n_err++; $display("FAIL stall_pc[%0d]: got %h expected %h", s, out_pc, STALL_PC); end
      n_vec++; if (out_inst !== mem_word(STALL_PC)) begin n_err++; $display("FAIL stall_inst[%0d]: got %h expected %h", s, out_inst, mem_word(STALL_PC)); end
`endif
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      stall = 1'b0; redirect = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL resume_valid[%0d]: got %b expected 1", k, out_valid); end
      n_vec++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL resume_pc[%0d]: got %h expected %h", k, out_pc, exp_pc); end
      n_vec++; if (out_inst !== mem_word(exp_pc)) begin n_err++; $display("FAIL resume_inst[%0d]: got %h expected %h", k, out_inst, mem_word(exp_pc)); end
      exp_pc = exp_pc + 14'd4;
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL rst_pre_level: got %0d expected 2", level); end
    rst = 1'b1; redirect = 1'b1; redirect_pc = 14'h104;
    #1;
    n_vec++; if (icache_re !== 1'b0) begin n_err++; $display("FAIL rst_mid_re: got %b expected 0", icache_re); end
    @(negedge clk);
    rst = 1'b0; redirect = 1'b0;
    #1;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_mid_level: got %0d expected 0", level); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
    n_vec++; if (icache_addr !== 14'h0) begin n_err++; $display("FAIL rst_mid_addr: got %h expected 0000", icache_addr); end
    n_vec++; if (icache_re !== 1'b1) begin n_err++; $display("FAIL rst_mid_re_after: got %b expected 1", icache_re); end
    repeat (LAT) @(negedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_first_valid: got %b expected 1", out_valid); end
    n_vec++; if (out_pc !== 14'h0) begin n_err++; $display("FAIL rst_first_pc: got %h expected 0000", out_pc); end
    n_vec++; if (out_inst !== mem_word(14'h0)) begin n_err++; $display("FAIL rst_first_inst: got %h expected %h", out_inst, mem_word(14'h0)); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_align_wrap();
    test_stall();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
